// File: rtl/tawas_rcn_slave.sv
// rtl/tawas_rcn_slave.sv - ring (RCN) slave bridging matched requests to a local bus
// Optional feature: define TAWAS_RCN_SLAVE_TIMEOUT_EN to abort a local access after
// 256 cycles without ack, answering with data 32'hDEADDEAD.
module tawas_rcn_slave #(
   parameter logic [23:0] ADDR_BASE = 24'h000000,
   parameter logic [23:0] ADDR_MASK = 24'hFF0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [68:0] rcn_in,
   output logic [68:0] rcn_out,
   output logic        cs,
   output logic        wr,
   output logic [3:0]  mask,
   output logic [23:0] addr,
   output logic [31:0] wdata,
   input  logic        ack,
   input  logic [31:0] rdata,
   output logic        pending
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCAL = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t      state;
   logic [68:0] rin;
   logic [68:0] rout;

   // Fields of the request being serviced; reused to build the response slot.
   logic        cap_wr;
   logic [2:0]  cap_id;
   logic [2:0]  cap_seq_hi;
   logic [3:0]  cap_mask;
   logic [21:0] cap_addr;
   logic [1:0]  cap_seq_lo;
   // Write data while the local access runs, response data afterwards.
   logic [31:0] data;

   logic        match;

`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
   logic [7:0]  tmo_cnt;
`endif

   // A valid request whose word address falls inside the claimed window.
   assign match = rin[68] && rin[67] &&
                  (((rin[55:34] ^ ADDR_BASE[23:2]) & ADDR_MASK[23:2]) == 22'd0);

   assign rcn_out = rout;
   assign wr      = cap_wr;
   assign mask    = cap_mask;
   assign addr    = {cap_addr, 2'b00};
   assign wdata   = data;

   // Ring input stage: every slot is registered before it is inspected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rin <= '0;
      end else begin
         rin <= rcn_in;
      end
   end

   // Slave FSM: claims a matching slot, runs the local access, then waits for
   // an empty slot to insert the response; everything else passes through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rout       <= '0;
         cap_wr     <= 1'b0;
         cap_id     <= '0;
         cap_seq_hi <= '0;
         cap_mask   <= '0;
         cap_addr   <= '0;
         cap_seq_lo <= '0;
         data       <= '0;
         cs         <= 1'b0;
         pending    <= 1'b0;
`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
         tmo_cnt    <= '0;
`endif
      end else begin
         // Default: forward the slot so unclaimed traffic keeps circulating.
         rout <= rin;
         case (state)
            IDLE: begin
               if (match) begin
                  cap_wr     <= rin[66];
                  cap_id     <= rin[65:63];
                  cap_seq_hi <= rin[62:60];
                  cap_mask   <= rin[59:56];
                  cap_addr   <= rin[55:34];
                  cap_seq_lo <= rin[33:32];
                  data       <= rin[31:0];
                  rout       <= '0;
                  cs         <= 1'b1;
                  pending    <= 1'b1;
                  state      <= LOCAL;
`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
                  tmo_cnt    <= '0;
`endif
               end
            end
            LOCAL: begin
               if (ack) begin
                  if (!cap_wr) begin
                     data <= rdata;
                  end
                  cs    <= 1'b0;
                  state <= RESP;
               end
`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
               else if (tmo_cnt == 8'hFF) begin
                  data  <= 32'hDEADDEAD;
                  cs    <= 1'b0;
                  state <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end
            RESP: begin
               // Only an empty slot may carry the response; busy slots pass on.
               if (!rin[68]) begin
                  rout    <= {1'b1, 1'b0, cap_wr, cap_id, cap_seq_hi, cap_mask,
                              cap_addr, cap_seq_lo, data};
                  pending <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               cs      <= 1'b0;
               pending <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tawas_rcn_slave.sv
// tb/tb_tawas_rcn_slave.sv - self-checking bench for tawas_rcn_slave
`timescale 1ns/1ps
module tb_tawas_rcn_slave;

   localparam logic [23:0] BASE = 24'h000000;
   localparam logic [23:0] WMSK = 24'hFF0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [68:0] rcn_in = '0;
   logic [68:0] rcn_out;
   logic        cs;
   logic        wr;
   logic [3:0]  mask;
   logic [23:0] addr;
   logic [31:0] wdata;
   logic        ack = 1'b0;
   logic [31:0] rdata = '0;
   logic        pending;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   tawas_rcn_slave #(.ADDR_BASE(BASE), .ADDR_MASK(WMSK)) dut (
      .clk(clk), .rst_n(rst_n), .rcn_in(rcn_in), .rcn_out(rcn_out),
      .cs(cs), .wr(wr), .mask(mask), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .pending(pending)
   );

   // Reference model: phase 0 = free, 1 = local access running, 2 = holding a response.
   typedef struct {
      logic [68:0] rin;
      logic [68:0] rout;
      int          phase;
      logic [68:0] req;
      logic [31:0] resp_data;
      int          waited;
   } model_t;

   model_t m;

   function automatic logic [68:0] mk_slot(logic req, logic w, logic [2:0] id, logic [4:0] seq,
                                           logic [3:0] mk, logic [23:0] a, logic [31:0] d);
      return {1'b1, req, w, id, seq[4:2], mk, a[23:2], seq[1:0], d};
   endfunction

   function automatic bit in_window(logic [68:0] s);
      logic [23:0] a;
      a = {s[55:34], 2'b00};
      return (a & WMSK & 24'hFFFFFC) == (BASE & WMSK & 24'hFFFFFC);
   endfunction

   function automatic model_t model_reset();
      model_t n;
      n.rin = '0; n.rout = '0; n.phase = 0; n.req = '0; n.resp_data = '0; n.waited = 0;
      return n;
   endfunction

   function automatic model_t model_step(model_t s, logic [68:0] in_slot, logic a, logic [31:0] rd);
      model_t n;
      n = s;
      n.rout = s.rin;
      if (s.phase == 0) begin
         if (s.rin[68] && s.rin[67] && in_window(s.rin)) begin
            n.req = s.rin; n.rout = '0; n.phase = 1; n.waited = 0;
         end
      end else if (s.phase == 1) begin
         if (a) begin
            n.resp_data = s.req[66] ? s.req[31:0] : rd;
            n.phase = 2;
         end
`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
         else if (s.waited == 255) begin
            n.resp_data = 32'hDEADDEAD;
            n.phase = 2;
         end else begin
            n.waited = s.waited + 1;
         end
`endif
      end else begin
         if (!s.rin[68]) begin
            n.rout = {2'b10, s.req[66:32], s.resp_data};
            n.phase = 0;
         end
      end
      n.rin = in_slot;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_step(m, rcn_in, ack, rdata);
   end

   task automatic check(string name, logic [68:0] act, logic [68:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_compare();
      check("rcn_out", rcn_out, m.rout);
      check("cs", 69'(cs), 69'(m.phase == 1));
      check("pending", 69'(pending), 69'(m.phase != 0));
      if (m.phase == 1) begin
         check("wr", 69'(wr), 69'(m.req[66]));
         check("mask", 69'(mask), 69'(m.req[59:56]));
         check("addr", 69'(addr), 69'({m.req[55:34], 2'b00}));
         check("wdata", 69'(wdata), 69'(m.req[31:0]));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_compare();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [68:0] s;
      logic [68:0] s2;
      logic [68:0] busy;
      int          dly;
      bit          in_local;
      int          cnt;

      #1;
      check("reset_rcn_out", rcn_out, 69'd0);
      check("reset_cs", 69'(cs), 69'd0);
      check("reset_pending", 69'(pending), 69'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Read hit, ack in the third local cycle.
      s = mk_slot(1'b1, 1'b0, 3'd3, 5'h16, 4'hF, 24'h000010, 32'h0);
      rcn_in = s; tick();
      rcn_in = '0; tick();
      check("rd_freed", rcn_out, 69'd0);
      check("rd_cs", 69'(cs), 69'd1);
      check("rd_wr", 69'(wr), 69'd0);
      check("rd_addr", 69'(addr), 69'h10);
      check("rd_mask", 69'(mask), 69'hF);
      tick(); tick();
      ack = 1'b1; rdata = 32'h12345678; tick();
      ack = 1'b0; rdata = '0;
      check("rd_cs_drop", 69'(cs), 69'd0);
      check("rd_pending", 69'(pending), 69'd1);
      tick();
      check("rd_resp", rcn_out, mk_slot(1'b0, 1'b0, 3'd3, 5'h16, 4'hF, 24'h000010, 32'h12345678));
      check("rd_idle", 69'(pending), 69'd0);
      tick();

      // Minimum latency: ack in first local cycle, no early insertion.
      s = mk_slot(1'b1, 1'b0, 3'd7, 5'h01, 4'h8, 24'h00FFFC, 32'h0);
      rcn_in = s; tick();
      rcn_in = '0; tick();
      ack = 1'b1; rdata = 32'h89ABCDEF; tick();
      ack = 1'b0;
      check("lat_no_early", rcn_out, 69'd0);
      tick();
      check("lat_resp", rcn_out, mk_slot(1'b0, 1'b0, 3'd7, 5'h01, 4'h8, 24'h00FFFC, 32'h89ABCDEF));
      tick();

      // Write hit: read data must be ignored.
      s = mk_slot(1'b1, 1'b1, 3'd5, 5'h09, 4'h3, 24'h000104, 32'hCAFEF00D);
      rcn_in = s; tick();
      rcn_in = '0; tick();
      check("wr_wr", 69'(wr), 69'd1);
      check("wr_addr", 69'(addr), 69'h104);
      check("wr_mask", 69'(mask), 69'h3);
      check("wr_wdata", 69'(wdata), 69'hCAFEF00D);
      ack = 1'b1; rdata = 32'h0BADBEEF; tick();
      ack = 1'b0; tick();
      check("wr_resp", rcn_out, mk_slot(1'b0, 1'b1, 3'd5, 5'h09, 4'h3, 24'h000104, 32'hCAFEF00D));
      tick();

      // Miss and response pass-through with a 2-cycle delay.
      s  = mk_slot(1'b1, 1'b0, 3'd2, 5'h03, 4'hF, 24'h010000, 32'h11112222);
      s2 = mk_slot(1'b0, 1'b1, 3'd6, 5'h1F, 4'h1, 24'h000020, 32'h33334444);
      rcn_in = s; tick();
      rcn_in = s2; tick();
      check("miss_pass", rcn_out, s);
      check("miss_cs", 69'(cs), 69'd0);
      rcn_in = '0; tick();
      check("resp_pass", rcn_out, s2);
      check("resp_cs", 69'(cs), 69'd0);
      tick(); tick();

      // Busy ring: response held until the first empty slot.
      s    = mk_slot(1'b1, 1'b0, 3'd1, 5'h0C, 4'hF, 24'h000400, 32'h0);
      busy = mk_slot(1'b1, 1'b0, 3'd4, 5'h11, 4'hF, 24'h220000, 32'h77778888);
      rcn_in = s; tick();
      rcn_in = busy; tick();
      ack = 1'b1; rdata = 32'hFEEDFACE; tick();
      ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("busy_pass", rcn_out, busy);
         check("busy_pending", 69'(pending), 69'd1);
      end
      rcn_in = '0; tick();
      check("busy_last", rcn_out, busy);
      tick();
      check("busy_resp", rcn_out, mk_slot(1'b0, 1'b0, 3'd1, 5'h0C, 4'hF, 24'h000400, 32'hFEEDFACE));
      tick();

      // Back-to-back hits: the second one circulates untouched.
      s  = mk_slot(1'b1, 1'b0, 3'd1, 5'h02, 4'hF, 24'h000200, 32'h0);
      s2 = mk_slot(1'b1, 1'b1, 3'd4, 5'h0A, 4'hC, 24'h000300, 32'hA5A5A5A5);
      rcn_in = s; tick();
      rcn_in = s2; tick();
      rcn_in = '0; tick();
      check("b2b_pass", rcn_out, s2);
      check("b2b_addr", 69'(addr), 69'h200);
      ack = 1'b1; rdata = 32'h55AA55AA; tick();
      ack = 1'b0; tick();
      check("b2b_resp", rcn_out, mk_slot(1'b0, 1'b0, 3'd1, 5'h02, 4'hF, 24'h000200, 32'h55AA55AA));
      tick();

      // Reset during the local access abandons it.
      s = mk_slot(1'b1, 1'b0, 3'd2, 5'h05, 4'hF, 24'h000040, 32'h0);
      rcn_in = s; tick();
      rcn_in = '0; tick();
      rst_n = 1'b0; #1;
      check("rst_cs", 69'(cs), 69'd0);
      check("rst_pending", 69'(pending), 69'd0);
      check("rst_rcn_out", rcn_out, 69'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ack = i[0]; rdata = 32'h99999999;
         tick();
         check("rst_no_resp", rcn_out, 69'd0);
      end
      ack = 1'b0;

`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
      s = mk_slot(1'b1, 1'b0, 3'd6, 5'h07, 4'hF, 24'h000080, 32'h0);
      rcn_in = s; tick();
      rcn_in = '0; tick();
      cnt = cs ? 1 : 0;
      while (cs && cnt < 300) begin
         tick();
         if (cs) cnt++;
      end
      check("tmo_cs_cycles", 69'(cnt), 69'd256);
      tick();
      check("tmo_resp", rcn_out, mk_slot(1'b0, 1'b0, 3'd6, 5'h07, 4'hF, 24'h000080, 32'hDEADDEAD));
      tick();
`else
      cnt = 0;
`endif

      // Randomized traffic checked against the model every cycle.
      in_local = 1'b0;
      dly = 0;
      for (int c = 0; c < 3000; c++) begin
         int sel;
         sel = int'($urandom_range(0, 99));
         if (sel < 40) begin
            rcn_in = '0;
         end else if (sel < 70) begin
            rcn_in = mk_slot(1'b1, 1'($urandom), 3'($urandom), 5'($urandom), 4'($urandom),
                             24'($urandom) & 24'h00FFFC, $urandom);
         end else if (sel < 85) begin
            rcn_in = mk_slot(1'b1, 1'($urandom), 3'($urandom), 5'($urandom), 4'($urandom),
                             {8'($urandom_range(1, 255)), 16'($urandom)}, $urandom);
         end else begin
            rcn_in = mk_slot(1'b0, 1'($urandom), 3'($urandom), 5'($urandom), 4'($urandom),
                             24'($urandom), $urandom);
         end
         rdata = $urandom;
         if (cs) begin
            if (!in_local) begin
               in_local = 1'b1;
               dly = int'($urandom_range(0, 4));
            end
            if (dly == 0) begin
               ack = 1'b1;
               in_local = 1'b0;
            end else begin
               ack = 1'b0;
               dly--;
            end
         end else begin
            in_local = 1'b0;
            ack = ($urandom_range(0, 9) == 0);
         end
         tick();
      end
      rcn_in = '0; ack = 1'b0;
      repeat (20) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tawas_rcn_slave.md
TAWAS_RCN_SLAVE -- requirements
Module: tawas_rcn_slave

Interface
REQ-001 SHALL provide parameter ADDR_BASE, default 24'h000000, as the base byte address of the claimed window.
REQ-002 SHALL provide parameter ADDR_MASK, default 24'hFF0000, which selects the address bits compared against ADDR_BASE.
REQ-003 SHALL have these ports:
  clk  input  1  clock.
  rst_n  input  1  asynchronous active-low reset.
  rcn_in  input  69  ring slot in.
  rcn_out  output  69  ring slot out.
  cs  output  1  local access strobe, held until ack.
  wr  output  1  local write (1) / read (0).
  mask  output  4  local byte enables.
  addr  output  24  local byte address, bits [1:0] always 0.
  wdata  output  32  local write data.
  ack  input  1  local access complete.
  rdata  input  32  local read data, valid with ack.
  pending  output  1  high in any state other than IDLE.
REQ-004 Slot format SHALL be: [68] valid; [67] 1=request/0=response; [66] wr; [65:63] master id; [62:60] seq hi; [59:56] mask; [55:34] addr[23:2]; [33:32] seq lo; [31:0] data.

Function
REQ-005 rcn_in SHALL be registered into rin each cycle; rcn_out SHALL be driven directly from register rout.
REQ-006 Match SHALL be rin[68] && rin[67] && ((rin[55:34] ^ ADDR_BASE[23:2]) & ADDR_MASK[23:2]) == 0.
REQ-007 FSM SHALL have states IDLE, LOCAL and RESP.
REQ-008 IDLE with match: capture rin[66:32], rout <= 0 (slot freed) and go to LOCAL, all in the same cycle.
REQ-009 LOCAL: cs=1 and wr/mask/addr/wdata SHALL be driven from the captured fields, stable until ack.
REQ-010 LOCAL with ack=1: capture rdata (read) or keep captured wdata (write) as response data, then go to RESP; cs SHALL be 0 from the following cycle.
REQ-011 RESP with rin[68]=0: rout <= {1,0,wr,id,seq hi,mask,addr[23:2],seq lo,data}, then go to IDLE.
REQ-012 RESP with rin[68]=1: rout <= rin and remain in RESP.
REQ-013 In every case not covered by REQ-008/011 (including matching requests seen while in LOCAL or RESP), rout SHALL be loaded from rin, so the request circulates and is retried later.
REQ-014 Only one transaction SHALL be outstanding at a time; ack SHALL be ignored outside LOCAL.
REQ-015 Minimum latency SHALL be 4 cycles from the rcn_in match to the response appearing on rcn_out, given ack in the first LOCAL cycle and an empty next slot.
REQ-016 Responses (rin[67]=0) SHALL never be consumed; they always pass through.
REQ-017 Ack and an empty slot arriving in the same LOCAL cycle SHALL NOT insert the response early; insertion happens no earlier than the first RESP cycle.

Reset
REQ-018 When rst_n is low, rin, rout, captured fields and data SHALL be 0, state SHALL be IDLE, and cs=0, pending=0, rcn_out=0, immediately and independently of clk.
REQ-019 Reset asserted in LOCAL or RESP SHALL abandon the transaction with no response issued.

Configuration
REQ-020 Macro TAWAS_RCN_SLAVE_TIMEOUT_EN SHALL control the local-access timeout.
- Defined: an 8-bit counter clears on entry to LOCAL and increments each LOCAL cycle without ack. When the count reaches 255 with ack still 0, the block goes to RESP with data 32'hDEADDEAD and drops cs. Ack in that same cycle takes priority.
- Undefined: no counter; LOCAL waits for ack indefinitely.

Verification
REQ-021 Read hit: request at addr 24'h000010, mask 4'hF, id 3, seq 5'h16; ack after 2 cycles with rdata 32'h12345678 -> freed slot, then response with [67]=0, id 3, seq 5'h16, data 32'h12345678.
REQ-022 Write hit: wdata 32'hCAFEF00D, mask 4'h3, addr 24'h000104 -> wr=1, addr 24'h000104, mask 4'h3 on the local bus; response [66]=1 with data 32'hCAFEF00D.
REQ-023 Miss and responses: request at addr 24'h010000 and any response slot -> rcn_out equals rcn_in delayed 2 cycles, cs never asserted.
REQ-024 Busy ring: all slots valid for 10 cycles after ack -> stays in RESP, pending=1; response inserted in the first empty slot.
REQ-025 Back-to-back hits: second matching request arrives while in LOCAL -> passes through unchanged; only the first is serviced.
REQ-026 Timeout (macro defined): ack never asserted -> cs high for exactly 256 cycles, then response data 32'hDEADDEAD; rst_n pulsed low mid-LOCAL -> cs=0 immediately and no response.
